// File: rtl/seq_detect_arbiter.sv
// Round-robin time-shared "1011" detector.
// One FSM step per cycle on the granted channel's saved context.
module seq_detect_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] data_in,
  input  logic [N_CH-1:0] ch_clear,
  output logic [N_CH-1:0] grant,
  output logic            det_valid,
  output logic [CH_W-1:0] det_ch,
  output logic            det_hit,
  output logic [1:0]      state_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] S1   = 2'd1;
  localparam logic [1:0] S10  = 2'd2;
  localparam logic [1:0] S101 = 2'd3;

  logic [1:0]      ctx [N_CH];
  logic [CH_W-1:0] last_grant;
  logic [N_CH-1:0] elig;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_any;
  logic [1:0]      cur;
  logic [1:0]      nxt;
  logic            bit_in;
  logic            hit;
  int              idx;

  assign elig = req & ~ch_clear;

  // Search from the slot after the last grant, wrapping once.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (!reset) begin
      for (int k = 1; k <= N_CH; k++) begin
        idx = int'(last_grant) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!gnt_any && elig[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = CH_W'(idx);
        end
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign cur    = ctx[gnt_idx];
  assign bit_in = data_in[gnt_idx];

  always_comb begin
    nxt = IDLE;
    hit = 1'b0;
    unique case (cur)
      IDLE: nxt = bit_in ? S1 : IDLE;
      S1:   nxt = bit_in ? S1 : S10;
      S10:  nxt = bit_in ? S101 : IDLE;
      S101: begin
        nxt = bit_in ? S1 : S10;
        hit = bit_in;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) ctx[i] <= IDLE;
      last_grant <= CH_W'(N_CH - 1);
      det_valid  <= 1'b0;
      det_hit    <= 1'b0;
      det_ch     <= '0;
      state_out  <= IDLE;
    end else begin
      for (int i = 0; i < N_CH; i++)
        if (ch_clear[i]) ctx[i] <= IDLE;
      det_valid <= gnt_any;
      det_hit   <= gnt_any & hit;
      if (gnt_any) begin
        ctx[gnt_idx] <= nxt;
        last_grant   <= gnt_idx;
        det_ch       <= gnt_idx;
        state_out    <= nxt;
      end
    end
  end

endmodule
